actel_seq_bank: RTL and testbench
=================================

# actel_seq_bank

Parametrised successor to the single-bit Actel S-type sequential logic module. Each lane is WIDTH bits wide: a 4:1 data mux with the Actel-style gated select (s1 = a1 | b1, s0 = a0 & b0), followed by a configurable-depth register pipeline with a global clock enable and valid tracking. The bank sits in the Actel-module library as the building block for registered datapath slices. Optionally, it includes a scan chain through every data register.

## Interface
Parameters:
- WIDTH, 8, data width of each mux input and of the output (1..64)
- STAGES, 1, number of register stages after the mux (1..4); sets latency

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  asynchronous, active-high reset; clears all registers
- en  input  1  clock enable; 0 stalls the whole pipeline
- in_valid  input  1  qualifies the current mux inputs
- d00, d01, d10, d11  input  WIDTH  mux data inputs
- a1, b1  input  1  select-high terms, s1 = a1 | b1
- a0, b0  input  1  select-low terms, s0 = a0 & b0
- out  output  WIDTH  last-stage data register
- out_valid  output  1  last-stage valid bit
- scan_en, scan_in  input  1  present only with ACTEL_SEQ_BANK_SCAN_EN
- scan_out  output  1  present only with ACTEL_SEQ_BANK_SCAN_EN

One clock; reset is asynchronous and active-high (clk, clr).

## Operation
- sel = {s1, s0} selects the stage-0 input: 00→d00, 01→d01, 10→d10, 11→d11.
- The selection is combinational from the current inputs and is never registered separately.
- Pipeline: data[0..STAGES-1], valid[0..STAGES-1]. out = data[STAGES-1]; out_valid = valid[STAGES-1].
- en=1 at a clock edge:
  - data[0] ← mux result; valid[0] ← in_valid.
  - data[i] ← data[i-1]; valid[i] ← valid[i-1].
- en=0: every data and valid register holds. This is a global stall with no bubble collapse.
- Data registers load even when in_valid=0. Consumers must qualify with out_valid.
- clr=1, at any time including mid-stream: all data registers → 0 and all valid registers → 0 immediately, without waiting for a clock edge.
- Release of clr: the first capture happens at the first rising edge where clr=0 and en=1.
- X on an unselected d input must not propagate to out.

## Timing
- Latency is exactly STAGES enabled clock edges from input to out/out_valid.
- Throughput is one word per enabled cycle.
- Stalled cycles add latency one-for-one.
- Reset values: out = 0, out_valid = 0, scan_out = 0.
- Input changes between edges have no effect on outputs; there is no combinational input→output path.
- When en and clr are both asserted, clr wins.

## Configuration
- Macro: ACTEL_SEQ_BANK_SCAN_EN.
- Defined:
  - scan_en, scan_in and scan_out ports exist.
  - When scan_en=1, all data registers form one shift chain of WIDTH*STAGES bits:
    - scan_in enters data[0] bit 0.
    - The chain runs bit 0→WIDTH-1 within a stage, then into the next stage's bit 0.
    - scan_out is data[STAGES-1] bit WIDTH-1.
  - Shifting happens on every rising edge, independent of en.
  - Valid registers hold during scan.
  - clr still overrides scan.
  - When scan_en=0, behaviour is identical to the undefined case.
- Undefined: the ports are absent and there is no scan logic. Area equals the functional pipeline only.

## Structure
- Package actel_pkg holds:
  - the sel_t 2-bit typedef
  - constants SEL_D00=2'b00, SEL_D01=2'b01, SEL_D10=2'b10, SEL_D11=2'b11
  - ACTEL_MAX_STAGES=4
- One sub-module, actel_pipe_stage: a WIDTH-bit data register plus valid bit with en, clr and an optional scan mux.
  - actel_seq_bank instantiates it STAGES times in a generate loop.
- Parameter checks are elaboration-time assertions: WIDTH in 1..64, STAGES in 1..ACTEL_MAX_STAGES.

## Test plan
- Select decode, WIDTH=8, STAGES=1: d00=0x11, d01=0x22, d10=0x44, d11=0x88, en=1.
  - a0=1, b0=0, a1=b1=0 → out=0x11.
  - a0=b0=1 → 0x22.
  - b1=1, a0=0 → 0x44.
  - a1=1, a0=b0=1 → 0x88.
  - Each result appears one edge later.
- Latency/valid, STAGES=3: in_valid=1 for one cycle with d00=0xA5 selected → out=0xA5, out_valid=1 on the 3rd edge only. out_valid=0 before and after.
- Stall, STAGES=2: a stream of 0x01,0x02,0x03 with en=0 for 2 cycles after the 2nd word → out and out_valid frozen during the stall. The sequence resumes intact with latency +2.
- Async reset mid-stream: assert clr between edges with out=0x5A, out_valid=1 → out=0 and out_valid=0 before the next edge. clr and en high together at an edge → still 0.
- Scan, macro defined, WIDTH=4, STAGES=2: scan_en=1, shift 8 bits 1,0,1,1,0,0,1,0 with en=0 → scan_out emits the pattern after 8 edges of latency. out_valid is unchanged throughout.
- Macro undefined: elaboration passes with no scan ports, and the functional scenarios above give identical results.

Source files
------------

// File: rtl/actel_pkg.sv
// actel_pkg: shared types and constants for the Actel-style sequential bank.
//   sel_t            2-bit mux select {s1, s0}
//   SEL_D00..SEL_D11 select codes for d00/d01/d10/d11
//   ACTEL_MAX_STAGES upper bound on pipeline depth
//   actel_sel()      Actel gated select: s1 = a1 | b1, s0 = a0 & b0
package actel_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_D00 = 2'b00;
  localparam sel_t SEL_D01 = 2'b01;
  localparam sel_t SEL_D10 = 2'b10;
  localparam sel_t SEL_D11 = 2'b11;

  localparam int ACTEL_MAX_STAGES = 4;

  function automatic sel_t actel_sel(input logic a1, input logic b1,
                                     input logic a0, input logic b0);
    return {a1 | b1, a0 & b0};
  endfunction

endpackage

// File: rtl/actel_pipe_stage.sv
// actel_pipe_stage: one WIDTH-bit data register plus its valid bit.
// Optional macro ACTEL_SEQ_BANK_SCAN_EN adds a serial scan path through the
// data register (bit 0 -> bit WIDTH-1); valid holds while scanning.
// Ports:
//   clk, clr         clock, async active-high clear
//   en               load enable (functional path)
//   d, v             incoming data / valid
//   scan_en, scan_in scan control and serial input (macro only)
//   q, qv            registered data / valid
module actel_pipe_stage
  import actel_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             v,
`ifdef ACTEL_SEQ_BANK_SCAN_EN
  input  logic             scan_en,
  input  logic             scan_in,
`endif
  output logic [WIDTH-1:0] q,
  output logic             qv
);

  logic [WIDTH-1:0] data_r;
  logic             valid_r;

`ifdef ACTEL_SEQ_BANK_SCAN_EN
  logic [WIDTH-1:0] shift_s;

  // Scan shift value: scan_in enters bit 0, each bit moves up one position.
  always_comb begin
    shift_s    = data_r;
    shift_s[0] = scan_in;
    for (int i = 1; i < WIDTH; i++) begin
      shift_s[i] = data_r[i-1];
    end
  end

  // Data/valid registers; scan shifts regardless of en, clr overrides all.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      data_r  <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
    end else if (scan_en) begin
      data_r  <= shift_s;
      valid_r <= valid_r;
    end else if (en) begin
      data_r  <= d;
      valid_r <= v;
    end else begin
      data_r  <= data_r;
      valid_r <= valid_r;
    end
  end
`else
  // Data/valid registers with global stall; clr clears immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      data_r  <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
    end else if (en) begin
      data_r  <= d;
      valid_r <= v;
    end else begin
      data_r  <= data_r;
      valid_r <= valid_r;
    end
  end
`endif

  assign q  = data_r;
  assign qv = valid_r;

endmodule

// File: rtl/actel_seq_bank.sv
// actel_seq_bank: WIDTH-bit 4:1 mux with Actel gated select feeding a
// STAGES-deep enabled register pipeline with valid tracking.
// Optional macro ACTEL_SEQ_BANK_SCAN_EN adds scan_en/scan_in/scan_out and
// chains every data register into one WIDTH*STAGES-bit shift register.
// Ports:
//   clk, clr              clock, async active-high clear
//   en                    global clock enable (0 stalls the pipeline)
//   in_valid              qualifies the current mux inputs
//   d00, d01, d10, d11    mux data inputs
//   a1, b1, a0, b0        select terms (s1 = a1|b1, s0 = a0&b0)
//   out, out_valid        last-stage data / valid registers
//   scan_en, scan_in      scan control / serial in (macro only)
//   scan_out              last-stage MSB (macro only)
module actel_seq_bank
  import actel_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] d00,
  input  logic [WIDTH-1:0] d01,
  input  logic [WIDTH-1:0] d10,
  input  logic [WIDTH-1:0] d11,
  input  logic             a1,
  input  logic             b1,
  input  logic             a0,
  input  logic             b0,
`ifdef ACTEL_SEQ_BANK_SCAN_EN
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out,
`endif
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  // Elaboration-time parameter range checks.
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("actel_seq_bank: WIDTH must be in 1..64");
  end
  if (STAGES < 1 || STAGES > ACTEL_MAX_STAGES) begin : g_bad_stages
    $error("actel_seq_bank: STAGES must be in 1..ACTEL_MAX_STAGES");
  end

  sel_t             sel_s;
  logic [WIDTH-1:0] mux_s;

  // Entry 0 is the mux result, entry i+1 is the output of stage i.
  logic [WIDTH-1:0] data_s  [0:STAGES];
  logic             valid_s [0:STAGES];

  assign sel_s = actel_sel(a1, b1, a0, b0);

  // 4:1 data mux; a case keeps X on unselected inputs from leaking through.
  always_comb begin
    mux_s = {WIDTH{1'b0}};
    case (sel_s)
      SEL_D00: mux_s = d00;
      SEL_D01: mux_s = d01;
      SEL_D10: mux_s = d10;
      SEL_D11: mux_s = d11;
      default: mux_s = {WIDTH{1'b0}};
    endcase
  end

  assign data_s[0]  = mux_s;
  assign valid_s[0] = in_valid;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
`ifdef ACTEL_SEQ_BANK_SCAN_EN
    logic chain_in_s;
    if (g == 0) begin : g_head
      assign chain_in_s = scan_in;
    end else begin : g_link
      // Previous stage's MSB feeds this stage's bit 0.
      assign chain_in_s = data_s[g][WIDTH-1];
    end
`endif
    actel_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .clr     (clr),
      .en      (en),
      .d       (data_s[g]),
      .v       (valid_s[g]),
`ifdef ACTEL_SEQ_BANK_SCAN_EN
      .scan_en (scan_en),
      .scan_in (chain_in_s),
`endif
      .q       (data_s[g+1]),
      .qv      (valid_s[g+1])
    );
  end

  assign out       = data_s[STAGES];
  assign out_valid = valid_s[STAGES];
`ifdef ACTEL_SEQ_BANK_SCAN_EN
  assign scan_out  = data_s[STAGES][WIDTH-1];
`endif

endmodule

// File: tb/tb_actel_seq_bank.sv
// tb_actel_seq_bank: directed bench for actel_seq_bank. Three instances with
// STAGES = 1, 2, 3 share the functional inputs; with ACTEL_SEQ_BANK_SCAN_EN a
// fourth WIDTH=4, STAGES=2 instance exercises the scan chain.
module tb_actel_seq_bank;

  logic       clk = 1'b0;
  logic       clr, en, in_valid;
  logic [7:0] d00, d01, d10, d11;
  logic       a1, b1, a0, b0;
  logic [7:0] out1, out2, out3;
  logic       ov1, ov2, ov3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef ACTEL_SEQ_BANK_SCAN_EN
  logic       scan_off = 1'b0;
  logic       so1, so2, so3, so4;
  logic       sen4, sin4;
  logic [3:0] out4;
  logic       ov4;
  logic [7:0] pat;
`endif

  actel_seq_bank #(.WIDTH(8), .STAGES(1)) dut1 (
    .clk(clk), .clr(clr), .en(en), .in_valid(in_valid),
    .d00(d00), .d01(d01), .d10(d10), .d11(d11),
    .a1(a1), .b1(b1), .a0(a0), .b0(b0),
`ifdef ACTEL_SEQ_BANK_SCAN_EN
    .scan_en(scan_off), .scan_in(scan_off), .scan_out(so1),
`endif
    .out(out1), .out_valid(ov1));

  actel_seq_bank #(.WIDTH(8), .STAGES(2)) dut2 (
    .clk(clk), .clr(clr), .en(en), .in_valid(in_valid),
    .d00(d00), .d01(d01), .d10(d10), .d11(d11),
    .a1(a1), .b1(b1), .a0(a0), .b0(b0),
`ifdef ACTEL_SEQ_BANK_SCAN_EN
    .scan_en(scan_off), .scan_in(scan_off), .scan_out(so2),
`endif
    .out(out2), .out_valid(ov2));

  actel_seq_bank #(.WIDTH(8), .STAGES(3)) dut3 (
    .clk(clk), .clr(clr), .en(en), .in_valid(in_valid),
    .d00(d00), .d01(d01), .d10(d10), .d11(d11),
    .a1(a1), .b1(b1), .a0(a0), .b0(b0),
`ifdef ACTEL_SEQ_BANK_SCAN_EN
    .scan_en(scan_off), .scan_in(scan_off), .scan_out(so3),
`endif
    .out(out3), .out_valid(ov3));

`ifdef ACTEL_SEQ_BANK_SCAN_EN
  actel_seq_bank #(.WIDTH(4), .STAGES(2)) dut4 (
    .clk(clk), .clr(clr), .en(en), .in_valid(in_valid),
    .d00(d00[3:0]), .d01(d01[3:0]), .d10(d10[3:0]), .d11(d11[3:0]),
    .a1(a1), .b1(b1), .a0(a0), .b0(b0),
    .scan_en(sen4), .scan_in(sin4), .scan_out(so4),
    .out(out4), .out_valid(ov4));
`endif

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic na1, input logic nb1,
                         input logic na0, input logic nb0);
    a1 = na1; b1 = nb1; a0 = na0; b0 = nb0;
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; in_valid = 1'b0;
    d00 = 8'h00; d01 = 8'h00; d10 = 8'h00; d11 = 8'h00;
    set_sel(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ACTEL_SEQ_BANK_SCAN_EN
    sen4 = 1'b0; sin4 = 1'b0;
`endif
    #2;
    check("reset_out1", {56'd0, out1}, 64'h0);
    check("reset_ov1",  {63'd0, ov1},  64'h0);
    check("reset_out3", {56'd0, out3}, 64'h0);
    check("reset_ov3",  {63'd0, ov3},  64'h0);
    tick();
    clr = 1'b0;
    #2;

    // Latency: single valid word 0xA5 through STAGES=3.
    en = 1'b1; in_valid = 1'b1; d00 = 8'hA5;
    set_sel(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("lat_e1_ov3",  {63'd0, ov3},  64'h0);
    check("lat_e1_out1", {56'd0, out1}, 64'hA5);
    check("lat_e1_ov1",  {63'd0, ov1},  64'h1);
    in_valid = 1'b0; d00 = 8'h00;
    tick();
    check("lat_e2_ov3",  {63'd0, ov3},  64'h0);
    check("lat_e2_out2", {56'd0, out2}, 64'hA5);
    tick();
    check("lat_e3_out3", {56'd0, out3}, 64'hA5);
    check("lat_e3_ov3",  {63'd0, ov3},  64'h1);
    tick();
    check("lat_e4_ov3",  {63'd0, ov3},  64'h0);

    // Select decode on STAGES=1.
    d00 = 8'h11; d01 = 8'h22; d10 = 8'h44; d11 = 8'h88; in_valid = 1'b1;
    set_sel(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("sel_00", {56'd0, out1}, 64'h11);
    set_sel(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check("sel_01", {56'd0, out1}, 64'h22);
    set_sel(1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    check("sel_10", {56'd0, out1}, 64'h44);
    set_sel(1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    check("sel_11", {56'd0, out1}, 64'h88);

    // Input changes between edges do not reach the output.
    d11 = 8'h77;
    #2;
    check("no_comb_path", {56'd0, out1}, 64'h88);

    // X on unselected inputs must not propagate.
    d00 = 8'h3C; d01 = 8'hxx; d10 = 8'hxx; d11 = 8'hxx;
    set_sel(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("x_isolation", {56'd0, out1}, 64'h3C);
    d01 = 8'h22; d10 = 8'h44; d11 = 8'h88;

    // Stall on STAGES=2: 01, 02, two stalled edges, 03.
    d00 = 8'h01; in_valid = 1'b1;
    tick();
    d00 = 8'h02;
    tick();
    check("stall_w1_out", {56'd0, out2}, 64'h01);
    check("stall_w1_ov",  {63'd0, ov2},  64'h1);
    en = 1'b0; d00 = 8'h03;
    tick();
    check("stall_hold1", {56'd0, out2}, 64'h01);
    tick();
    check("stall_hold2", {56'd0, out2}, 64'h01);
    check("stall_hold2_ov", {63'd0, ov2}, 64'h1);
    en = 1'b1;
    tick();
    check("stall_w2", {56'd0, out2}, 64'h02);
    in_valid = 1'b0; d00 = 8'hFF;
    tick();
    check("stall_w3", {56'd0, out2}, 64'h03);
    check("stall_w3_ov", {63'd0, ov2}, 64'h1);
    tick();
    check("stall_tail_ov", {63'd0, ov2}, 64'h0);

    // Async clear mid-stream.
    in_valid = 1'b1; d00 = 8'h5A;
    tick();
    tick();
    check("pre_clr_out", {56'd0, out2}, 64'h5A);
    check("pre_clr_ov",  {63'd0, ov2},  64'h1);
    #2;
    clr = 1'b1;
    #1;
    check("async_clr_out2", {56'd0, out2}, 64'h0);
    check("async_clr_ov2",  {63'd0, ov2},  64'h0);
    check("async_clr_out1", {56'd0, out1}, 64'h0);
    tick();
    check("clr_wins_out1", {56'd0, out1}, 64'h0);
    check("clr_wins_ov1",  {63'd0, ov1},  64'h0);
    #2;
    clr = 1'b0;
    tick();
    check("post_clr_out1", {56'd0, out1}, 64'h5A);
    check("post_clr_ov1",  {63'd0, ov1},  64'h1);

`ifdef ACTEL_SEQ_BANK_SCAN_EN
    // Scan chain, WIDTH=4 STAGES=2, shift 1,0,1,1,0,0,1,0 with en=0.
    #2;
    clr = 1'b1;
    #2;
    clr = 1'b0; en = 1'b0; sen4 = 1'b1;
    pat = 8'b0100_1101;
    for (int k = 0; k < 16; k++) begin
      sin4 = (k < 8) ? pat[k] : 1'b0;
      tick();
      if (k >= 7) begin
        check("scan_out", {63'd0, so4}, {63'd0, pat[k-7]});
      end
      if (k == 7) begin
        check("scan_out4_word", {60'd0, out4}, 64'hB);
      end
      check("scan_ov_hold", {63'd0, ov4}, 64'h0);
    end
    sen4 = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
